// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key event queue.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : scan-code prefix bytes (E0 extended, F0 break)
//   key_evt_t                       : one queued event {ext, brk, code}
//   dec_state_t                     : prefix decoder states
//   evt_to_key32()                  : expands an event into the legacy 32-bit key word
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_t;

  // Legacy formats: 000000cc, 0000F0cc, 0000E0cc, 00E0F0cc.
  function automatic logic [31:0] evt_to_key32(input key_evt_t evt);
    logic [31:0] key;
    key = {24'h0, evt.code};
    if (evt.ext && evt.brk)
      key[23:8] = {PS2_PREFIX_EXT, PS2_PREFIX_BRK};
    else if (evt.ext)
      key[15:8] = PS2_PREFIX_EXT;
    else if (evt.brk)
      key[15:8] = PS2_PREFIX_BRK;
    return key;
  endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Event drain port of the PS/2 key event queue.
//   evt_valid : queue non-empty (producer -> consumer)
//   evt_key   : head event in 32-bit key format (producer -> consumer)
//   evt_count : queue occupancy (producer -> consumer)
//   evt_ready : consumer accepts the head event (consumer -> producer)
// master = the queue, slave = the consumer.
interface ps2_key_event_queue_if #(
  parameter int CNT_W = 4
);

  logic             evt_valid;
  logic             evt_ready;
  logic [31:0]      evt_key;
  logic [CNT_W-1:0] evt_count;

  modport master (output evt_valid, evt_key, evt_count, input evt_ready);
  modport slave  (input evt_valid, evt_key, evt_count, output evt_ready);

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw lines, samples data on each
// ps2_clk falling edge, checks start/parity/stop on the 11th bit and abandons
// partial frames after TIMEOUT_CYCLES clocks without a falling edge.
//   clk, clrn            : system clock, async active-low reset
//   ps2_clk, ps2_data    : raw PS/2 lines
//   byte_valid           : one-cycle pulse, byte_data holds a good byte
//   byte_data            : received byte (LSB first on the wire)
//   frame_err            : one-cycle pulse on a bad frame or timeout
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   data_bit;
  logic [3:0]             bit_cnt;
  logic [9:0]             shift;
  logic [TW-1:0]          idle_cnt;
  logic [10:0]            frame;
  logic                   frame_ok;

  assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_bit = data_sync[SYNC_STAGES-1];

  // Frame as it stands once the 11th bit is included: [0] start, [8:1] data,
  // [9] parity, [10] stop. Odd parity means data+parity has an odd popcount.
  assign frame    = {data_bit, shift};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      // Lines idle high, so reset the synchronisers high to avoid a false edge.
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_prev   <= 1'b1;
      bit_cnt    <= '0;
      shift      <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here read the
      // previous-cycle value of the others, which is what a flop chain is.
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev   <= clk_sync[SYNC_STAGES-1];
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            byte_data  <= frame[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift   <= {data_bit, shift[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 keyboard decoder with an event FIFO.
//   clk, clrn    : system clock, async active-low reset
//   ps2_clk/data : raw PS/2 lines
//   en           : decode enable (0 discards bytes, idles the decoder)
//   ovf_clr      : clears the sticky overflow flag
//   evt          : drain port (evt_valid/evt_ready/evt_key/evt_count)
//   cur_key      : most recently decoded event, 32-bit legacy format
//   overflow     : sticky, an event was dropped on a full FIFO
//   frame_err    : one-cycle pulse on a bad frame or timeout
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  input  logic                         en,
  input  logic                         ovf_clr,
  ps2_key_event_queue_if.master        evt,
  output logic [31:0]                  cur_key,
  output logic                         overflow,
  output logic                         frame_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ok;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign byte_ok = byte_valid & en;

  // ---------------- prefix decoder ----------------
  dec_state_t state;
  dec_state_t state_nxt;
  logic       emit;
  key_evt_t   emit_evt;
  logic       last_make_valid;
  logic [8:0] last_make;       // {ext, code}
  logic       repeat_hit;
  logic       fire;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    emit      = 1'b0;
    emit_evt  = '0;
    if (byte_ok) begin
      if (byte_data == PS2_PREFIX_EXT) begin
        state_nxt = EXT;
      end else if (byte_data == PS2_PREFIX_BRK) begin
        state_nxt = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        state_nxt     = IDLE;
        emit          = 1'b1;
        emit_evt.ext  = (state == EXT || state == EXT_BRK);
        emit_evt.brk  = (state == BRK || state == EXT_BRK);
        emit_evt.code = byte_data;
      end
    end
  end

  // A typematic repeat is a make of the key already held down.
  assign repeat_hit = (SUPPRESS_REPEAT != 0) && emit && !emit_evt.brk &&
                      last_make_valid && (last_make == {emit_evt.ext, emit_evt.code});
  assign fire = emit && !repeat_hit;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state           <= IDLE;
      last_make_valid <= 1'b0;
      last_make       <= '0;
      cur_key         <= '0;
    end else begin
      if (!en) begin
        state           <= IDLE;
        last_make_valid <= 1'b0;
      end else begin
        state <= state_nxt;
        if (fire) begin
          if (!emit_evt.brk) begin
            last_make_valid <= 1'b1;
            last_make       <= {emit_evt.ext, emit_evt.code};
          end else if (last_make == {emit_evt.ext, emit_evt.code}) begin
            last_make_valid <= 1'b0;
          end
        end
      end
      // cur_key follows every emitted event, even one the FIFO drops.
      if (fire)
        cur_key <= evt_to_key32(emit_evt);
    end
  end

  // ---------------- event FIFO ----------------
  key_evt_t       mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CNT_W-1:0] count;
  logic           full;
  logic           pop;
  logic           push;
  logic           drop;

  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign pop  = (count != '0) && evt.evt_ready;
  assign push = fire && (!full || pop);
  assign drop = fire && full && !pop;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; an entry is only read after it was written,
  // and the output is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= emit_evt;
  end

  assign evt.evt_valid = (count != '0);
  assign evt.evt_count = count;
  assign evt.evt_key   = (count != '0) ? evt_to_key32(mem[rd_ptr]) : 32'h0;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
module tb_ps2_key_event_queue;

  localparam int FIFO_DEPTH     = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF           = 8;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        en = 1'b1;
  logic        ovf_clr = 1'b0;
  logic [31:0] cur_key;
  logic        overflow;
  logic        frame_err;

  ps2_key_event_queue_if #(.CNT_W(CNT_W)) evt_bus ();

  ps2_key_event_queue #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .SUPPRESS_REPEAT (1)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .en        (en),
    .ovf_clr   (ovf_clr),
    .evt       (evt_bus),
    .cur_key   (cur_key),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          ferr_seen = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_key;

  // Scoreboard: every accepted event must match the next expected key.
  always @(negedge clk) begin
    if (clrn) begin
      if (frame_err) ferr_seen++;
      if (evt_bus.evt_valid && evt_bus.evt_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL evt_unexpected: got %08h, expected no event", evt_bus.evt_key);
        end else begin
          exp_key = exp_q.pop_front();
          if (evt_bus.evt_key !== exp_key) begin
            errors++;
            $display("FAIL evt_key: got %08h, expected %08h", evt_bus.evt_key, exp_key);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of a frame: start, data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || evt_bus.evt_valid) && n < 500) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || evt_bus.evt_valid) begin
      errors++;
      $display("FAIL %s_drain: %0d events still expected, evt_valid=%b",
               name, exp_q.size(), evt_bus.evt_valid);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (evt_bus.evt_valid !== 1'b0 || evt_bus.evt_key !== 32'h0 ||
        evt_bus.evt_count !== '0 || cur_key !== 32'h0 ||
        overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%b key=%08h count=%0d cur_key=%08h ovf=%b ferr=%b, expected all 0",
               name, evt_bus.evt_valid, evt_bus.evt_key, evt_bus.evt_count,
               cur_key, overflow, frame_err);
    end
  endtask

  task automatic check_cur_key(input string name, input logic [31:0] exp);
    checks++;
    if (cur_key !== exp) begin
      errors++;
      $display("FAIL %s_cur_key: got %08h, expected %08h", name, cur_key, exp);
    end
  endtask

  task automatic check_no_event(input string name);
    checks++;
    if (evt_bus.evt_valid !== 1'b0 || evt_bus.evt_count !== '0) begin
      errors++;
      $display("FAIL %s_no_event: evt_valid=%b count=%0d, expected 0/0",
               name, evt_bus.evt_valid, evt_bus.evt_count);
    end
  endtask

  task automatic test_reset();
    evt_bus.evt_ready = 1'b1;
    clrn = 1'b0;
    tick(3);
    check_outputs_zero("reset_held");
    clrn = 1'b1;
    tick(5);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_make_break();
    exp_q.push_back(32'h0000001C);
    send_byte(8'h1C);
    exp_q.push_back(32'h0000F01C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    wait_drain("make_break");
    check_cur_key("make_break", 32'h0000F01C);
  endtask

  task automatic test_ext();
    exp_q.push_back(32'h0000E075);
    send_byte(8'hE0);
    send_byte(8'h75);
    exp_q.push_back(32'h00E0F075);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    wait_drain("ext");
    check_cur_key("ext", 32'h00E0F075);
    // F0 then E0 restarts as an extended sequence.
    exp_q.push_back(32'h0000E06B);
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h6B);
    exp_q.push_back(32'h00E0F06B);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    wait_drain("ext_restart");
  endtask

  task automatic test_typematic();
    exp_q.push_back(32'h0000001C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    exp_q.push_back(32'h0000F01C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    exp_q.push_back(32'h0000001C);
    send_byte(8'h1C);
    wait_drain("typematic");
    check_cur_key("typematic", 32'h0000001C);
    // Dropping en forgets the held key.
    en = 1'b0;
    tick(2);
    en = 1'b1;
    tick(2);
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_seen;
    send_frame(8'h1C, 1'b1, 11);
    tick(4);
    checks++;
    if (ferr_seen - f0 != 1) begin
      errors++;
      $display("FAIL parity_err_pulse: got %0d cycles, expected 1", ferr_seen - f0);
    end
    check_no_event("parity_err");
    f0 = ferr_seen;
    send_frame(8'h1C, 1'b0, 3);
    tick(TIMEOUT_CYCLES / 2);
    checks++;
    if (ferr_seen - f0 != 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d pulses, expected 0", ferr_seen - f0);
    end
    tick(TIMEOUT_CYCLES);
    checks++;
    if (ferr_seen - f0 != 1) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d cycles, expected 1", ferr_seen - f0);
    end
    exp_q.push_back(32'h0000001C);
    send_byte(8'h1C);
    wait_drain("after_timeout");
    check_cur_key("after_timeout", 32'h0000001C);
  endtask

  task automatic test_overflow();
    evt_bus.evt_ready = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      if (i < FIFO_DEPTH) exp_q.push_back({24'h0, 8'(8'h21 + i)});
      send_byte(8'(8'h21 + i));
    end
    tick(2);
    checks++;
    if (evt_bus.evt_count !== CNT_W'(FIFO_DEPTH) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: count=%0d ovf=%b, expected %0d/1",
               evt_bus.evt_count, overflow, FIFO_DEPTH);
    end
    checks++;
    if (evt_bus.evt_key !== 32'h00000021) begin
      errors++;
      $display("FAIL ovf_head: got %08h, expected 00000021", evt_bus.evt_key);
    end
    check_cur_key("ovf_dropped", {24'h0, 8'(8'h21 + FIFO_DEPTH)});
    evt_bus.evt_ready = 1'b1;
    wait_drain("ovf");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, expected 1", overflow);
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_enable_reset();
    en = 1'b0;
    send_byte(8'hF0);
    send_byte(8'h1C);
    tick(4);
    check_no_event("en_off");
    check_cur_key("en_off", {24'h0, 8'(8'h21 + FIFO_DEPTH)});
    en = 1'b1;
    tick(2);
    // The last make was forgotten while disabled, so the same key is new again.
    exp_q.push_back({24'h0, 8'(8'h21 + FIFO_DEPTH)});
    send_byte(8'(8'h21 + FIFO_DEPTH));
    wait_drain("en_rearm");
    send_frame(8'h5A, 1'b0, 5);
    clrn = 1'b0;
    tick(2);
    check_outputs_zero("reset_mid_frame");
    clrn = 1'b1;
    tick(5);
    exp_q.push_back(32'h0000002A);
    send_byte(8'h2A);
    wait_drain("after_reset");
    check_cur_key("after_reset", 32'h0000002A);
  endtask

  initial begin
    evt_bus.evt_ready = 1'b1;
    test_reset();
    test_make_break();
    test_ext();
    test_typematic();
    test_frame_err();
    test_overflow();
    test_enable_reset();
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
- Parametrised successor to the single-register PS/2 keyboard decoder.
- Receives PS/2 frames directly, with its own frame receiver, parity check and timeout.
- Decodes E0/F0 prefixes into make/break events and filters typematic repeats.
- Queues events in a FIFO with a valid/ready drain port and keeps a legacy 32-bit cur_key mirror for existing consumers.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of two, >= 2.
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data; >= 2.
- TIMEOUT_CYCLES, 50000: clk cycles with no ps2_clk falling edge before a partial frame is abandoned.
- SUPPRESS_REPEAT, 1: 1 drops repeated make codes of the key currently held.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock
- ps2_data  in  1  raw PS/2 data
- en  in  1  decode enable
- evt_ready  in  1  consumer accepts the head event
- ovf_clr  in  1  clears the sticky overflow flag
- evt_valid  out  1  FIFO non-empty
- evt_key  out  32  head event: 000000cc, 0000F0cc, 0000E0cc, 00E0F0cc
- evt_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- cur_key  out  32  most recently decoded event, same format
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse on a bad frame or timeout

Behaviour:
- Reset: clk, single clock domain; clrn asynchronous, active-low. While clrn=0, all outputs are 0, the FSM is IDLE, the FIFO is empty, the bit counter is 0, last_make is invalid.
- Receiver, sampling:
  - Both PS/2 lines pass through SYNC_STAGES flops.
  - A falling edge is synced ps2_clk going 1->0 between consecutive cycles.
  - Each falling edge samples the synced ps2_data and increments the bit counter 0..10.
- Receiver, frame check on the 11th bit:
  - Valid frame: start=0, stop=1, and odd parity over data+parity.
  - Valid frame gives a byte_valid pulse for 1 cycle, data LSB-first.
  - Any violation gives a frame_err pulse; the byte is discarded and the counter returns to 0.
- Timeout: if the counter is non-zero and TIMEOUT_CYCLES cycles pass with no falling edge, the counter returns to 0 and frame_err pulses.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions on byte_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> emit make, go IDLE.
  - EXT: E0 -> EXT; F0 -> EXT_BRK; other byte -> emit ext make, go IDLE.
  - BRK: F0 -> BRK; E0 -> EXT (corrupt sequence restarts); other byte -> emit break, go IDLE.
  - EXT_BRK: E0 -> EXT; F0 -> EXT_BRK; other byte -> emit ext break, go IDLE.
  - E1 and all other non-prefix bytes are ordinary codes.
- Repeat filter (SUPPRESS_REPEAT=1):
  - A make whose {ext,code} equals last_make is dropped entirely: no FIFO write, no cur_key update.
  - An accepted make loads last_make.
  - A break matching last_make invalidates it.
  - A break of another key leaves it unchanged.
- Enable: en=0 keeps the receiver running but discards its bytes, forces the FSM to IDLE and invalidates last_make. The FIFO still drains.
- cur_key: updated on every emitted event, the cycle after the final byte_valid, whether or not the FIFO accepts it.
- FIFO storage and output:
  - Entries are 10 bits {ext, brk, code}; evt_key is combinationally expanded from the head entry (show-ahead).
  - evt_valid = count != 0. A pop happens when evt_valid && evt_ready.
- FIFO push rules:
  - Push on emit when not full.
  - Full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - Full with no pop: the event is dropped and overflow is set.
  - ovf_clr clears overflow; if ovf_clr and a new drop coincide, overflow stays 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: 11th falling edge detected at cycle N -> byte_valid at N+1 -> FIFO write and cur_key at N+2 -> evt_valid visible at N+2 when the FIFO was empty.
- evt_ready while empty has no effect.

Decomposition:
- ps2_pkg holds:
  - constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0;
  - typedef key_evt_t {ext, brk, code[7:0]};
  - function evt_to_key32() producing the 32-bit format;
  - the FSM state enum.
- One sub-module, ps2_frame_rx: synchroniser, edge detect, shift register, parity/stop check, timeout. Outputs byte_valid, byte_data, frame_err.
- The top module holds the FSM, repeat filter, FIFO and cur_key.

Test Plan:
- Frames 1C, then F0 1C; evt_ready=1 -> events 0000001C then 0000F01C in order; cur_key ends 0000F01C.
- Frames E0 75, then E0 F0 75 -> 0000E075 then 00E0F075.
- Typematic 1C,1C,1C,F0 1C,1C -> events 0000001C, 0000F01C, 0000001C only.
- Bad frame: 1C with parity=1 -> frame_err pulse, no event. Next 3 clean bits then idle TIMEOUT_CYCLES -> frame_err pulse; a following 1C frame decodes correctly.
- evt_ready=0, FIFO_DEPTH+1 distinct makes -> evt_count=FIFO_DEPTH, overflow=1, head = first key; then drain -> FIFO_DEPTH events in order. ovf_clr -> overflow=0.
- en=0 during F0 1C -> no event; clrn pulse mid-frame -> outputs 0; next full frame decodes normally.
